// File: rtl/elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage
//
// Chain of STAGES elastic (skid-buffered) register stages.  Each stage keeps
// a main entry that feeds the next stage and a skid entry that catches a
// payload arriving while the main entry is blocked.  A stage's ready toward
// its upstream is the inverse of its skid valid bit.  Because that bit is a
// register, there is no combinational path from out_ready to in_ready, and
// full throughput is kept under back-pressure.
//
// Parameters
//   WIDTH          payload width in bits (>= 1)
//   STAGES         number of chained elastic stages (1..8)
//
// Ports
//   clk            clock, all state updates on posedge
//   reset_n        asynchronous active-low reset
//   flush          synchronous kill of every held entry (valid bits only)
//   in_valid       upstream payload valid
//   in_ready       block can accept (registered)
//   in_data        upstream payload
//   out_valid      downstream payload valid (registered)
//   out_ready      downstream accepts
//   out_data       downstream payload (registered)
//   occupancy      number of set main + skid valid bits
//
// Optional build macro ELASTIC_PIPE_STAGE_PERF_EN adds:
//   stall_cycles   saturating count of cycles with out_valid=1, out_ready=0
//   bubble_cycles  saturating count of cycles with out_valid=0, out_ready=1
// -----------------------------------------------------------------------------
module elastic_pipe_stage #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WIDTH-1:0]                 out_data,
   output logic [$clog2(2*STAGES+1)-1:0]    occupancy
`ifdef ELASTIC_PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]                      stall_cycles,
   output logic [31:0]                      bubble_cycles
`endif
);

   localparam int unsigned OCC_W = $clog2(2*STAGES+1);

   logic [STAGES-1:0] main_v;
   logic [STAGES-1:0] skid_v;
   logic [WIDTH-1:0]  main_d [STAGES];
   logic [WIDTH-1:0]  skid_d [STAGES];

   // valid_chain[i] is the valid seen by stage i (bit STAGES is the block
   // output); ready_chain[i+1] is the ready seen by stage i (bit 0 is the
   // block input ready).
   logic [STAGES:0]   valid_chain;
   logic [STAGES:0]   ready_chain;
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [STAGES-1:0] accept;
   logic [STAGES-1:0] drain;

   always_comb begin
      valid_chain = {main_v, in_valid};
      ready_chain = {out_ready, ~skid_v};
      up_data[0]  = in_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
         up_data[i] = main_d[i-1];
      end
      // An upstream handshake during flush is dropped, so it is never
      // captured; a downstream handshake still drains normally.
      accept = valid_chain[STAGES-1:0] & ~skid_v & {STAGES{~flush}};
      drain  = main_v & ready_chain[STAGES:1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_v <= '0;
         skid_v <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            main_d[i] <= '0;
            skid_d[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            if (flush) begin
               // Only the valid bits are killed; payload registers keep
               // their contents.
               main_v[i] <= 1'b0;
               skid_v[i] <= 1'b0;
            end else if (!main_v[i] || drain[i]) begin
               if (skid_v[i]) begin
                  // Skid entry is older than anything arriving now, and
                  // ready was low, so no new payload competes for main.
                  main_d[i] <= skid_d[i];
                  main_v[i] <= 1'b1;
                  skid_v[i] <= 1'b0;
               end else begin
                  main_v[i] <= accept[i];
                  if (accept[i]) begin
                     main_d[i] <= up_data[i];
                  end
               end
            end else if (accept[i]) begin
               skid_d[i] <= up_data[i];
               skid_v[i] <= 1'b1;
            end
         end
      end
   end

   assign in_ready  = ready_chain[0];
   assign out_valid = valid_chain[STAGES];
   assign out_data  = main_d[STAGES-1];

   always_comb begin
      occupancy = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(main_v[i]) + OCC_W'(skid_v[i]);
      end
   end

`ifdef ELASTIC_PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (!out_valid && out_ready && (bubble_cycles != '1)) begin
            bubble_cycles <= bubble_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/elastic_pipe_stage.md
ELASTIC_PIPE_STAGE -- requirements
Module: elastic_pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter STAGES, default 2, number of chained elastic stages (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept; driven from a register, no combinational path from out_ready.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid, registered.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload, registered.
REQ-012 SHALL have port occupancy  output  $clog2(2*STAGES+1)  total held entries.

Function
REQ-013 Each stage SHALL hold one main entry and one skid entry, each with its own valid bit.
REQ-014 Handshake SHALL complete on a posedge where valid and ready are both 1; valid/data SHALL remain stable while valid=1 and ready=0.
REQ-015 Stage ready toward its upstream SHALL equal NOT(skid valid), registered.
REQ-016 On accept: main empty or main draining this cycle -> payload to main; otherwise -> skid.
REQ-017 When main drains and skid is full, skid SHALL move to main on the same edge and skid SHALL clear.
REQ-018 Entries SHALL leave in arrival order; no loss, duplication or reordering.
REQ-019 Latency SHALL be exactly STAGES cycles from in handshake to out_valid when out_ready is held 1.
REQ-020 Throughput SHALL be one payload per cycle with out_ready held 1.
REQ-021 With out_ready=0, the block SHALL absorb up to 2*STAGES payloads, then drop in_ready.
REQ-022 After out_ready returns to 1, in_ready SHALL reassert no later than STAGES cycles later.
REQ-023 occupancy SHALL equal the count of set main+skid valid bits, updated each edge.
REQ-024 flush=1 SHALL clear every valid bit on the next edge; occupancy SHALL read 0, in_ready 1, out_valid 0 after it.
REQ-025 An in handshake in a flush cycle SHALL be discarded; an out handshake in a flush cycle SHALL complete normally.
REQ-026 Data registers SHALL not be cleared by flush; only valid bits are.
REQ-027 in_data while in_valid=0 SHALL have no effect on state.

Reset
REQ-028 reset_n=0 SHALL immediately clear all valid bits, data registers to 0, counters to 0, independent of clk.
REQ-029 During and after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL discard all held entries; first edge after release behaves as empty block.

Configuration
REQ-031 Macro ELASTIC_PIPE_STAGE_PERF_EN defined SHALL add outputs stall_cycles (32) and bubble_cycles (32).
REQ-032 stall_cycles SHALL count cycles with out_valid=1 and out_ready=0; bubble_cycles SHALL count cycles with out_valid=0 and out_ready=1; both saturate at 0xFFFFFFFF, reset to 0, unaffected by flush.
REQ-033 Without the macro these ports and counters SHALL not exist; all other behaviour identical.

Verification (WIDTH=32, STAGES=3)
REQ-034 Stream 0x1..0x10 back-to-back, out_ready=1 -> out_data 0x1 exactly 3 cycles after first accept, 16 consecutive out_valid cycles, in order.
REQ-035 out_ready=0, in_valid=1 continuously -> exactly 6 accepts, in_ready=0, occupancy=6; release out_ready -> 6 payloads out in order, none lost.
REQ-036 occupancy=4 then flush=1 with in_valid=1 data 0xDEAD -> next cycle occupancy=0, out_valid=0, 0xDEAD never emitted.
REQ-037 reset_n=0 asynchronously between edges with occupancy=5 -> outputs clear immediately; after release occupancy=0, in_ready=1.
REQ-038 Random in_valid/out_ready (50%) over 10000 payloads -> scoreboard exact in-order match, in_ready never depends combinationally on out_ready.
REQ-039 With ELASTIC_PIPE_STAGE_PERF_EN: 5 cycles out_valid=1/out_ready=0 -> stall_cycles=5; 7 idle cycles with out_ready=1 -> bubble_cycles=7.
